// File: rtl/fir_out_fifo_if.sv
// Sample/handshake bundle between the FIR output FIFO and its neighbours.
// The filter writes DIN/VIN, the consumer reads DOUT/VOUT and drives READY.
interface fir_out_fifo_if #(
  parameter int DW    = 9,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] DIN;
  logic          VIN;
  logic [DW-1:0] DOUT;
  logic          VOUT;
  logic          READY;
  logic [AW:0]   COUNT;
  logic          FULL;
  logic          EMPTY;
  logic          OVF;

  modport master (
    output DIN, VIN, READY,
    input  DOUT, VOUT, COUNT, FULL, EMPTY, OVF
  );

  modport slave (
    input  DIN, VIN, READY,
    output DOUT, VOUT, COUNT, FULL, EMPTY, OVF
  );
endinterface

// File: rtl/fir_out_fifo.sv
// Show-ahead output FIFO behind the FIR filter, with sticky overflow flag.
// Optional synchronous flush input CLR is enabled by defining FIFO_CLR_EN.
module fir_out_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 8
) (
  input  logic CLK,
  input  logic RST,
`ifdef FIFO_CLR_EN
  input  logic CLR,
`endif
  fir_out_fifo_if.slave io
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, push, pop, flush, mem_we;

`ifdef FIFO_CLR_EN
  assign flush = CLR;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    pop      = !empty && io.READY;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    push     = io.VIN && (!full || pop);
    mem_we   = push && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (io.VIN && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset; stale entries are masked by COUNT.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wr_ptr_q] <= io.DIN;
  end

  assign io.COUNT = count_q;
  assign io.FULL  = full;
  assign io.EMPTY = empty;
  assign io.OVF   = ovf_q;
  assign io.VOUT  = !empty;
  assign io.DOUT  = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_fir_out_fifo.sv
// Self-checking bench for fir_out_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_fir_out_fifo;
  localparam int DW    = 9;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef FIFO_CLR_EN
  logic clr = 1'b0;
`endif

  fir_out_fifo_if #(.DW(DW), .DEPTH(DEPTH)) io ();

  fir_out_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
`ifdef FIFO_CLR_EN
    .CLR (clr),
`endif
    .io  (io)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;

  wire [16:0] dut_vec = {io.VOUT, io.DOUT, io.COUNT, io.FULL, io.EMPTY, io.OVF};

  function automatic logic [16:0] exp_vec();
    logic          v;
    logic [DW-1:0] d;
    logic [AW:0]   c;
    v = (mq.size() != 0);
    d = v ? mq[0] : '0;
    c = (AW+1)'(mq.size());
    return {v, d, c, (mq.size() == DEPTH), (mq.size() == 0), m_ovf};
  endfunction

  task automatic drive(input bit vin, input logic [DW-1:0] din, input bit ready);
    io.VIN   = vin;
    io.DIN   = din;
    io.READY = ready;
  endtask

  // One clock edge; the model applies the same inputs the DUT sees at that edge.
  task automatic tick();
    bit            do_pop, do_push, flush, vin;
    logic [DW-1:0] din;
    flush = rst;
`ifdef FIFO_CLR_EN
    flush = flush || clr;
`endif
    vin     = io.VIN;
    din     = io.DIN;
    do_pop  = (mq.size() > 0) && io.READY;
    do_push = vin && ((mq.size() < DEPTH) || do_pop);
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(din);
      if (vin && !do_push) m_ovf = 1'b1;
    end
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, base + DW'(i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (dut_vec !== 17'b0_000000000_0000_0_1_0) begin
      n_err++;
      $display("FAIL reset_idle got %h exp %h", dut_vec, 17'b0_000000000_0000_0_1_0);
    end
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_idle_hold got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_pass_through();
    logic [DW-1:0] vals [3];
    vals = '{9'h001, 9'h0FF, 9'h1AA};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b1);
      tick();
      n_cmp++;
      if (io.DOUT !== vals[i] || io.VOUT !== 1'b1 || io.COUNT > 1) begin
        n_err++;
        $display("FAIL pass_through[%0d] got dout=%h vout=%b count=%0d exp dout=%h vout=1 count<=1",
                 i, io.DOUT, io.VOUT, io.COUNT, vals[i]);
      end
    end
    drive(1'b0, '0, 1'b1);
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec() || io.EMPTY !== 1'b1) begin
      n_err++;
      $display("FAIL pass_through_empty got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_fill_drain();
    drive(1'b1, 9'h1EE, 1'b1);
    n_cmp++;
    if (io.VOUT !== 1'b0) begin
      n_err++;
      $display("FAIL no_bypass got vout=%b exp 0", io.VOUT);
    end
    drive(1'b0, '0, 1'b0);
    fill(9'h010);
    n_cmp++;
    if (io.FULL !== 1'b1 || io.COUNT !== 4'd8) begin
      n_err++;
      $display("FAIL fill_full got full=%b count=%0d exp full=1 count=8", io.FULL, io.COUNT);
    end
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (io.DOUT !== 9'h010 + DW'(i) || io.VOUT !== 1'b1) begin
        n_err++;
        $display("FAIL drain[%0d] got dout=%h vout=%b exp dout=%h vout=1",
                 i, io.DOUT, io.VOUT, 9'h010 + DW'(i));
      end
      tick();
    end
    n_cmp++;
    if (io.EMPTY !== 1'b1 || io.VOUT !== 1'b0 || io.DOUT !== '0) begin
      n_err++;
      $display("FAIL drain_empty got empty=%b vout=%b dout=%h exp 1/0/000", io.EMPTY, io.VOUT, io.DOUT);
    end
  endtask

  task automatic test_overflow();
    fill(9'h020);
    drive(1'b1, 9'h1FF, 1'b0);
    tick();
    n_cmp++;
    if (io.COUNT !== 4'd8 || io.OVF !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL overflow got count=%0d ovf=%b exp count=8 ovf=1", io.COUNT, io.OVF);
    end
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (io.DOUT !== 9'h020 + DW'(i) || io.OVF !== 1'b1) begin
        n_err++;
        $display("FAIL overflow_drain[%0d] got dout=%h ovf=%b exp dout=%h ovf=1",
                 i, io.DOUT, io.OVF, 9'h020 + DW'(i));
      end
      tick();
    end
    n_cmp++;
    if (io.EMPTY !== 1'b1 || io.OVF !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_sticky got empty=%b ovf=%b exp 1/1", io.EMPTY, io.OVF);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (io.OVF !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_clear got ovf=%b exp 0", io.OVF);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] exp_seq [DEPTH];
    fill(9'h030);
    drive(1'b1, 9'h055, 1'b1);
    tick();
    n_cmp++;
    if (io.COUNT !== 4'd8 || io.OVF !== 1'b0 || io.DOUT !== 9'h031) begin
      n_err++;
      $display("FAIL full_push_pop got count=%0d ovf=%b dout=%h exp count=8 ovf=0 dout=031",
               io.COUNT, io.OVF, io.DOUT);
    end
    for (int i = 0; i < DEPTH - 1; i++) exp_seq[i] = 9'h031 + DW'(i);
    exp_seq[DEPTH-1] = 9'h055;
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (io.DOUT !== exp_seq[i]) begin
        n_err++;
        $display("FAIL wrap_drain[%0d] got %h exp %h", i, io.DOUT, exp_seq[i]);
      end
      tick();
    end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL wrap_empty got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'h040 + DW'(i), 1'b0);
      tick();
    end
    n_cmp++;
    if (io.COUNT !== 4'd5) begin
      n_err++;
      $display("FAIL mid_count got %0d exp 5", io.COUNT);
    end
    rst = 1'b1;
    drive(1'b1, 9'h1AB, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    n_cmp++;
    if (io.COUNT !== 4'd0 || io.VOUT !== 1'b0 || io.OVF !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got count=%0d vout=%b ovf=%b exp 0/0/0", io.COUNT, io.VOUT, io.OVF);
    end
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec() || io.EMPTY !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_discard got %h exp %h", dut_vec, exp_vec());
    end
`ifdef FIFO_CLR_EN
    fill(9'h060);
    drive(1'b1, 9'h0AA, 1'b0);
    tick();
    clr = 1'b1;
    drive(1'b1, 9'h0BB, 1'b1);
    tick();
    clr = 1'b0;
    drive(1'b0, '0, 1'b0);
    n_cmp++;
    if (io.COUNT !== 4'd0 || io.VOUT !== 1'b0 || io.OVF !== 1'b0 || io.DOUT !== '0) begin
      n_err++;
      $display("FAIL clr_flush got count=%0d vout=%b ovf=%b exp 0/0/0", io.COUNT, io.VOUT, io.OVF);
    end
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL clr_discard got %h exp %h", dut_vec, exp_vec());
    end
`endif
  endtask

  task automatic test_random();
    bit ready_bias;
    for (int c = 0; c < 800; c++) begin
      ready_bias = ((c / 100) % 2) == 1;
      rst = ($urandom_range(0, 149) == 0);
`ifdef FIFO_CLR_EN
      clr = ($urandom_range(0, 99) == 0);
`endif
      drive($urandom_range(0, 3) != 0, DW'($urandom),
            ready_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d] got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    rst = 1'b0;
`ifdef FIFO_CLR_EN
    clr = 1'b0;
`endif
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_pass_through();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
